la_main: RTL and testbench
==========================

# la_main

Single-clock 8-channel logic analyzer capture core, the top of the analyzer datapath. It samples an 8-bit input bus every clock and waits, armed, for a trigger pattern. On trigger it records timestamped samples into an internal buffer. A host drains the buffer through a 32-bit show-ahead read port.

## Interface
- `TRIG_VALUE`, default 8'h05: sample value that fires the trigger.
- `DEPTH`, default 8: buffer entries; power of two, ≥2.
- `TS_W`, default 24: timestamp width; `TS_W + 8` must equal 32.
- `clk  in  1`: sampling/system clock, rising edge.
- `_rst  in  1`: asynchronous, active-high reset (port keeps the codebase name).
- `data  in  8`: probed bus; asynchronous to the design.
- `i_btn  in  1`: user button, asynchronous, level.
- `i_read  in  1`: pop request for the head entry.
- `o_available  out  1`: buffer holds at least one unread entry.
- `o_run  out  1`: capture in progress.
- `o_data  out  32`: head entry, `{timestamp[TS_W-1:0], sample[7:0]}`; 0 when empty.

## Operation
- Input conditioning:
  - `data` is registered each cycle into `s_q`; `s_prev` holds the previous `s_q`.
  - `i_btn` passes through a 2-FF synchronizer plus rising-edge detect, giving `btn_p`.
- State machine: ARMED, CAPTURE, DONE. Reset state is ARMED.
- ARMED:
  - Trigger when `s_q == TRIG_VALUE && s_prev != TRIG_VALUE` (rising match), or on `btn_p` (forced trigger).
  - On trigger: write `{0, s_q}`, clear the timestamp counter to 1, go to CAPTURE.
- CAPTURE:
  - Timestamp counter increments every cycle and saturates at all-ones.
  - A store writes `{ts, s_q}`; store conditions are set in Configuration.
  - When the write fills the buffer (count reaches DEPTH), go to DONE.
  - `btn_p` is ignored in CAPTURE.
- DONE:
  - No writes.
  - Go to ARMED when the buffer becomes empty through reads.
  - `btn_p` in DONE flushes the buffer and goes to ARMED.
- Read port:
  - `o_data` shows the head entry combinationally from the buffer.
  - `i_read && o_available` pops one entry per clock.
  - `i_read` while empty is ignored.
  - Reads are legal in every state. A simultaneous read and write in CAPTURE keeps the count unchanged.
- `o_run` = (state == CAPTURE).
- `o_available` = (count != 0).
- Reset values: `o_run` = 0, `o_available` = 0, `o_data` = 0, count = 0, pointers = 0, timestamp = 0, `s_q` = 0, `s_prev` = 0, synchronizer = 0.

## Timing
- `data` → `s_q`: 1 cycle. The trigger is evaluated on `s_q`, so the first entry is written 2 edges after `data` changes.
- `o_run` rises the cycle after the trigger edge and falls the cycle after the filling write.
- `i_btn` → `btn_p`: 2–3 cycles.
- Pop takes effect at the clock edge; the next head is visible right after that edge.
- Reset mid-capture: the buffer is discarded immediately (asynchronous). Operation resumes in ARMED on the first edge after release.
- A buffer full while in CAPTURE can only occur at the DONE transition; no overflow path exists.
- Timestamp saturation: entries keep writing with ts = all-ones.

## Configuration
- `LA_CHANGE_ONLY_EN` defined:
  - In CAPTURE, store only when `s_q != last_stored` (transitional storage). `last_stored` is updated on every write.
  - The timestamp gives time since trigger.
- Not defined: store every CAPTURE cycle, so timestamps are consecutive (1, 2, 3, …).

## Structure
- Package `la_pkg`:
  - state enum `la_state_t` (ARMED/CAPTURE/DONE)
  - entry typedef `la_entry_t` (`ts`, `sample`)
  - `LA_WORD_W` = 32
- Sub-module `la_fifo`: synchronous single-clock FIFO, show-ahead, with count, async reset, and flush input. The capture FSM, conditioning and timestamp logic stay in `la_main`.

## Test plan
- Reset value check: assert `_rst` for 5 ns → `o_run` = 0, `o_available` = 0, `o_data` = 0.
- Change-only capture (macro defined): `data` steps 0,5,4,5,4,5,9,5,4,1, one step every 10 ns (clk period 4 ns).
  - Expect 8 entries with samples 5,4,5,4,5,9,5,4 and ts[0] = 0 with strictly increasing ts.
  - Then DONE, `o_run` = 0, `o_available` = 1, and the final 1 is not stored.
- No re-trigger while full: the next 5 after DONE leaves the count at 8. Popping all 8 with `i_read` gives `o_available` = 0 and state ARMED; a following 0→5 starts a new capture.
- Forced trigger: hold `data` = 126 and pulse `i_btn` → capture starts within 3 cycles with entry 0 = 32'h0000_007E.
- Reset mid-capture: after the trigger on 5 and two stores, pulse `_rst`.
  - Expect `o_available` = 0 immediately.
  - Then 5,9 → new capture entry 0 sample 5.
- Macro undefined: trigger, then constant `data` → entries hold identical samples with ts 0,1,2,…,7; DONE after 8 cycles.

Source files
------------

// File: rtl/la_pkg.sv
// Shared types and widths for the la_main logic-analyzer capture core.
package la_pkg;

    localparam int unsigned LA_WORD_W   = 32;
    localparam int unsigned LA_SAMPLE_W = 8;
    localparam int unsigned LA_TS_W     = LA_WORD_W - LA_SAMPLE_W;

    typedef enum logic [1:0] {
        ARMED   = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } la_state_t;

    typedef struct packed {
        logic [LA_TS_W-1:0]     ts;
        logic [LA_SAMPLE_W-1:0] sample;
    } la_entry_t;

endpackage

// File: rtl/la_fifo.sv
// Single-clock show-ahead FIFO with occupancy count and synchronous flush.
module la_fifo #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         wr,
    input  logic [W-1:0]                 wr_data,
    input  logic                         rd,
    output logic [W-1:0]                 rd_data,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          rd_ok;
    logic          wr_ok;

    assign rd_ok = rd && (count != '0);
    assign wr_ok = wr && ((count != CW'(DEPTH)) || rd_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; empty reads are masked below.
    always_ff @(posedge clk) begin
        if (wr_ok && !flush) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/la_main.sv
// Logic-analyzer capture core: input conditioning, trigger/capture FSM, timestamping.
// Optional LA_CHANGE_ONLY_EN: in CAPTURE store only samples that differ from the last stored one.
module la_main
    import la_pkg::*;
#(
    parameter logic [7:0]  TRIG_VALUE = 8'h05,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned TS_W       = LA_TS_W
) (
    input  logic                 clk,
    input  logic                 _rst,
    input  logic [7:0]           data,
    input  logic                 i_btn,
    input  logic                 i_read,
    output logic                 o_available,
    output logic                 o_run,
    output logic [LA_WORD_W-1:0] o_data
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    la_state_t       state;
    la_state_t       state_n;
    logic [7:0]      s_q;
    logic [7:0]      s_prev;
    logic [1:0]      btn_sync;
    logic            btn_q;
    logic            btn_p;
    logic [TS_W-1:0] ts;
    logic [CW-1:0]   count;
    logic            trig_match;
    logic            rd_ok;
    logic            store_en;
    logic            wr;
    logic            flush;
    logic            ts_clr;
    la_entry_t       wr_entry;

    // Sample register, button synchronizer and edge detect.
    always_ff @(posedge clk or posedge _rst) begin
        if (_rst) begin
            s_q      <= '0;
            s_prev   <= '0;
            btn_sync <= '0;
            btn_q    <= 1'b0;
        end else begin
            s_q      <= data;
            s_prev   <= s_q;
            btn_sync <= {btn_sync[0], i_btn};
            btn_q    <= btn_sync[1];
        end
    end

    assign btn_p      = btn_sync[1] & ~btn_q;
    assign trig_match = (s_q == TRIG_VALUE) && (s_prev != TRIG_VALUE);
    assign rd_ok      = i_read && (count != '0);

`ifdef LA_CHANGE_ONLY_EN
    logic [7:0] last_stored;

    always_ff @(posedge clk or posedge _rst) begin
        if (_rst)    last_stored <= '0;
        else if (wr) last_stored <= s_q;
    end

    assign store_en = (s_q != last_stored);
`else
    assign store_en = 1'b1;
`endif

    always_ff @(posedge clk or posedge _rst) begin
        if (_rst) state <= ARMED;
        else      state <= state_n;
    end

    always_comb begin
        state_n         = state;
        wr              = 1'b0;
        flush           = 1'b0;
        ts_clr          = 1'b0;
        wr_entry.ts     = LA_TS_W'(ts);
        wr_entry.sample = s_q;
        case (state)
            ARMED: begin
                if (trig_match || btn_p) begin
                    wr          = 1'b1;
                    wr_entry.ts = '0;
                    ts_clr      = 1'b1;
                    state_n     = CAPTURE;
                end
            end
            CAPTURE: begin
                wr = store_en;
                // Full is only reachable through this write, so DONE is entered here.
                if (wr && !rd_ok && (count == CW'(DEPTH - 1))) state_n = DONE;
            end
            DONE: begin
                if (btn_p) begin
                    flush   = 1'b1;
                    state_n = ARMED;
                end else if ((count == '0) || ((count == CW'(1)) && rd_ok)) begin
                    state_n = ARMED;
                end
            end
            default: state_n = ARMED;
        endcase
    end

    // Time since trigger; saturates so late entries still carry a valid stamp.
    always_ff @(posedge clk or posedge _rst) begin
        if (_rst)                                  ts <= '0;
        else if (ts_clr)                           ts <= TS_W'(1);
        else if ((state == CAPTURE) && (ts != '1)) ts <= ts + TS_W'(1);
    end

    la_fifo #(
        .W     (LA_WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (_rst),
        .flush   (flush),
        .wr      (wr),
        .wr_data (wr_entry),
        .rd      (i_read),
        .rd_data (o_data),
        .count   (count)
    );

    assign o_available = (count != '0);
    assign o_run       = (state == CAPTURE);

endmodule

// File: tb/tb_la_main.sv
// Directed testbench for la_main; expectations follow LA_CHANGE_ONLY_EN when defined.
module tb_la_main;
    import la_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data;
    logic        i_btn;
    logic        i_read;
    logic        o_available;
    logic        o_run;
    logic [31:0] o_data;

    int          n_cmp = 0;
    int          n_err = 0;
    bit          ok;
    int          cnt;
    logic [23:0] prev_ts;

    localparam logic [7:0] CO_SEQ [10] = '{8'd0, 8'd5, 8'd4, 8'd5, 8'd4, 8'd5, 8'd9, 8'd5, 8'd4, 8'd1};
    localparam logic [7:0] CO_EXP [8]  = '{8'd5, 8'd4, 8'd5, 8'd4, 8'd5, 8'd9, 8'd5, 8'd4};

    always #2 clk = ~clk;

    la_main dut (
        .clk         (clk),
        ._rst        (rst),
        .data        (data),
        .i_btn       (i_btn),
        .i_read      (i_read),
        .o_available (o_available),
        .o_run       (o_run),
        .o_data      (o_data)
    );

    task automatic do_reset();
        rst = 1'b1; data = 8'd0; i_btn = 1'b0; i_read = 1'b0;
        #5;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_run(input bit lvl, input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (o_run === lvl) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; data = 8'd0; i_btn = 1'b0; i_read = 1'b0;
        #5;
        n_cmp++; if (o_run !== 1'b0) begin n_err++; $display("FAIL reset_run: got %b want 0", o_run); end
        n_cmp++; if (o_available !== 1'b0) begin n_err++; $display("FAIL reset_avail: got %b want 0", o_available); end
        n_cmp++; if (o_data !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h want 00000000", o_data); end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_capture();
`ifdef LA_CHANGE_ONLY_EN
        @(negedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            data = CO_SEQ[i];
            #10;
        end
        repeat (4) @(negedge clk);
`else
        @(negedge clk);
        data = 8'd5;
        wait_run(1'b1, 4, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL capture_start: o_run not seen, got %b want 1", ok); end
        cnt = 0;
        while ((o_run === 1'b1) && (cnt < 20)) begin
            cnt++;
            @(negedge clk);
        end
        n_cmp++; if (cnt != 7) begin n_err++; $display("FAIL capture_len: run cycles got %0d want 7", cnt); end
`endif
        n_cmp++; if (o_run !== 1'b0) begin n_err++; $display("FAIL capture_done_run: got %b want 0", o_run); end
        n_cmp++; if (o_available !== 1'b1) begin n_err++; $display("FAIL capture_done_avail: got %b want 1", o_available); end
    endtask

    task automatic test_no_retrigger();
        data = 8'd0;
        repeat (2) @(negedge clk);
        data = 8'd5;
        repeat (4) @(negedge clk);
        n_cmp++; if (o_run !== 1'b0) begin n_err++; $display("FAIL full_retrig_run: got %b want 0", o_run); end
        n_cmp++; if (dut.state !== DONE) begin n_err++; $display("FAIL full_retrig_state: got %0d want %0d", dut.state, DONE); end
    endtask

    task automatic test_drain();
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (o_available !== 1'b1) begin n_err++; $display("FAIL drain_avail[%0d]: got %b want 1", i, o_available); end
`ifdef LA_CHANGE_ONLY_EN
            n_cmp++; if (o_data[7:0] !== CO_EXP[i]) begin n_err++; $display("FAIL drain_sample[%0d]: got %h want %h", i, o_data[7:0], CO_EXP[i]); end
            if (i == 0) begin
                n_cmp++; if (o_data[31:8] !== 24'd0) begin n_err++; $display("FAIL drain_ts0: got %0d want 0", o_data[31:8]); end
            end else begin
                n_cmp++; if (!(o_data[31:8] > prev_ts)) begin n_err++; $display("FAIL drain_ts_inc[%0d]: got %0d want > %0d", i, o_data[31:8], prev_ts); end
            end
            prev_ts = o_data[31:8];
`else
            n_cmp++; if (o_data !== {24'(i), 8'h05}) begin n_err++; $display("FAIL drain_word[%0d]: got %h want %h", i, o_data, {24'(i), 8'h05}); end
`endif
            i_read = 1'b1;
            @(negedge clk);
        end
        i_read = 1'b0;
        n_cmp++; if (o_available !== 1'b0) begin n_err++; $display("FAIL drain_empty: got %b want 0", o_available); end
        n_cmp++; if (dut.state !== ARMED) begin n_err++; $display("FAIL drain_state: got %0d want %0d", dut.state, ARMED); end
        i_read = 1'b1;
        @(negedge clk);
        i_read = 1'b0;
        n_cmp++; if (o_available !== 1'b0) begin n_err++; $display("FAIL empty_read_avail: got %b want 0", o_available); end
        n_cmp++; if (o_data !== 32'h0) begin n_err++; $display("FAIL empty_read_data: got %h want 00000000", o_data); end
    endtask

    task automatic test_rearm();
        data = 8'd0;
        repeat (2) @(negedge clk);
        data = 8'd5;
        wait_run(1'b1, 4, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL rearm_run: o_run not seen, got %b want 1", ok); end
        n_cmp++; if (o_data !== 32'h0000_0005) begin n_err++; $display("FAIL rearm_entry0: got %h want 00000005", o_data); end
        do_reset();
    endtask

    task automatic test_forced();
        data = 8'd126;
        repeat (3) @(negedge clk);
        i_btn = 1'b1;
        @(negedge clk);
        i_btn = 1'b0;
        wait_run(1'b1, 4, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL forced_run: o_run not seen, got %b want 1", ok); end
        n_cmp++; if (o_data !== 32'h0000_007E) begin n_err++; $display("FAIL forced_entry0: got %h want 0000007e", o_data); end
        i_btn = 1'b1;
        @(negedge clk);
        i_btn = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (o_run !== 1'b1) begin n_err++; $display("FAIL capture_btn_run: got %b want 1", o_run); end
        n_cmp++; if (o_data !== 32'h0000_007E) begin n_err++; $display("FAIL capture_btn_head: got %h want 0000007e", o_data); end
    endtask

`ifndef LA_CHANGE_ONLY_EN
    task automatic test_btn_flush();
        wait_run(1'b0, 12, ok);
        n_cmp++; if (o_available !== 1'b1) begin n_err++; $display("FAIL flush_pre_avail: got %b want 1", o_available); end
        i_btn = 1'b1;
        @(negedge clk);
        i_btn = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++; if (o_available !== 1'b0) begin n_err++; $display("FAIL flush_avail: got %b want 0", o_available); end
        n_cmp++; if (dut.state !== ARMED) begin n_err++; $display("FAIL flush_state: got %0d want %0d", dut.state, ARMED); end
    endtask
`endif

    task automatic test_reset_mid();
        do_reset();
        data = 8'd5;
        wait_run(1'b1, 4, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL mid_first_run: o_run not seen, got %b want 1", ok); end
        data = 8'd9;
        repeat (2) @(negedge clk);
        #1;
        rst  = 1'b1;
        data = 8'd0;
        #1;
        n_cmp++; if (o_available !== 1'b0) begin n_err++; $display("FAIL mid_rst_avail: got %b want 0", o_available); end
        n_cmp++; if (o_run !== 1'b0) begin n_err++; $display("FAIL mid_rst_run: got %b want 0", o_run); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        data = 8'd5;
        @(negedge clk);
        data = 8'd9;
        wait_run(1'b1, 4, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL mid_second_run: o_run not seen, got %b want 1", ok); end
        n_cmp++; if (o_data !== 32'h0000_0005) begin n_err++; $display("FAIL mid_entry0: got %h want 00000005", o_data); end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_no_retrigger();
        test_drain();
        test_rearm();
        test_forced();
`ifndef LA_CHANGE_ONLY_EN
        test_btn_flush();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
